dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data memory (10-bit word address, 32-bit data, cs/we control).
- Shares the memory between port 0 (CPU load/store stage) and port 1 (debug/DMA loader).
- Handles per-cycle arbitration, registered memory command issue, read-return routing, and a bounded bus lock for atomic read-modify-write sequences.

Parameters:
- ADDR_W, 10, memory word address width
- DATA_W, 32, data width
- FIXED_PRIO, 0, 0 = round-robin, 1 = port 0 always wins
- LOCK_MAX, 16, max cycles a lock may be held without an owner grant before forced release

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0/req1  in  1  access request; held with we/addr/wdata/lock stable until gnt sampled high
- we0/we1  in  1  1 = write, 0 = read
- addr0/addr1  in  ADDR_W  word address
- wdata0/wdata1  in  DATA_W  write data
- lock0/lock1  in  1  request bus lock with this access
- gnt0/gnt1  out  1  combinational accept; access is taken at the edge where gnt=1
- rvalid0/rvalid1  out  1  read data valid pulse
- rdata0/rdata1  out  DATA_W  read data, equal to mem_dataOut; meaningful only with rvalid
- lock_err0/lock_err1  out  1  one-cycle pulse on forced lock release
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_dataIn  out  DATA_W  memory write data
- mem_dataOut  in  DATA_W  memory read data; valid the cycle after a cs & !we cycle

Behaviour:
- Reset (async, rst_n=0):
  - mem_cs, mem_we, mem_addr, mem_dataIn, rvalid*, lock_err* = 0.
  - State = ARB, last-granted pointer = 1 (port 0 favoured first), lock counter = 0, pending reads cleared.
- Grant (combinational, at most one gnt high):
  - ARB, single req: grant it.
  - ARB, both req: FIXED_PRIO=1 grants port 0; otherwise grant the port not last granted.
  - LOCKED: only the owner can be granted; the other port's gnt=0.
- Issue (edge with gntk=1):
  - mem_cs<=1, mem_we<=wek, mem_addr<=addrk, mem_dataIn<=wdatak, last<=k.
  - Edge with no grant: mem_cs<=0, mem_we<=0, mem_addr/mem_dataIn hold.
  - mem_we never 1 while mem_cs=0.
- Throughput and latency:
  - One access per cycle with back-to-back grants.
  - Write grant in cycle N → memory write at end of cycle N+1.
  - Read grant in cycle N → rvalidk=1 in cycle N+2 (single pulse per read), rdatak=mem_dataOut.
  - Requests complete in grant order; a 2-entry owner pipeline tracks pending reads.
- States:
  - ARB → LOCKED(k) when granted with lockk=1; lock counter cleared.
  - LOCKED(k) → ARB when owner is granted with lockk=0. That access completes normally; the other port may be granted the next cycle.
  - LOCKED(k): owner grant with lockk=1 clears counter. Otherwise counter increments each cycle.
  - Counter reaching LOCK_MAX → ARB, lock_errk=1 for one cycle, counter cleared, pointer set so the other port wins the next tie.
- Boundary conditions:
  - Address wrap: none; addr passes through unmodified.
  - Simultaneous unlock access and other-port request: other port waits one cycle.
  - Requester dropping req without a grant is legal; no side effects.
  - Reset mid-operation: outputs clear immediately; in-flight reads are discarded, no rvalid after rst_n rises.

Test Plan:
1. Port 0 writes addr 4 = 999, then reads addr 4.
   - gnt0 in the request cycle.
   - Next cycle: mem_cs=1, mem_we=1, mem_addr=4, mem_dataIn=999.
   - Read: rvalid0 two cycles after gnt, rdata0=999, rvalid1=0.
2. Both ports request continuously, FIXED_PRIO=0.
   - Grants go 0,1,0,1.
   - Rerun with FIXED_PRIO=1: gnt0 every cycle, gnt1 never.
3. Port 1 reads addr 0..3 back-to-back (memory preloaded 100,101,102,103).
   - 4 consecutive gnt1.
   - rvalid1 high 4 consecutive cycles with rdata1 = 100..103 in order.
4. Port 0 locked read addr 5, port 1 requesting throughout.
   - gnt1=0 until port 0 writes addr 5 with lock0=0.
   - gnt1=1 the following cycle.
5. Port 0 locks and then drops req (LOCK_MAX=16).
   - lock_err0 pulses exactly 16 cycles after lock entry.
   - Waiting port 1 is granted the next cycle.
6. rst_n low one cycle after a read grant.
   - mem_cs=0 immediately.
   - No rvalid0 after release.
   - First post-reset tie grants port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory (port 0 = CPU, port 1 = debug/DMA).
// Latency: grant is combinational; the memory command is registered one cycle later; read data returns 2 cycles after grant.
// Backpressure: a requester holds req/we/addr/wdata/lock until it sees gnt high; a locked bus stalls the non-owner.
//
// Ports:
//   clk, rst_n                       clock and asynchronous active-low reset
//   req*/we*/addr*/wdata*/lock*      requester side access request (k = 0, 1)
//   gnt*                             combinational accept; access is taken at the edge where gnt=1
//   rvalid*/rdata*                   read return, rdata* mirrors mem_dataOut and is qualified by rvalid*
//   lock_err*                        one-cycle pulse when a lock is forcibly released after LOCK_MAX idle cycles
//   mem_cs/mem_we/mem_addr/mem_dataIn registered memory command, mem_dataOut read data (one cycle after a read command)

`timescale 1ns/1ps

module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  // port 0 (CPU load/store)
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              lock0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  output logic              lock_err0,
  // port 1 (debug/DMA loader)
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              lock_err1,
  // memory side
  output logic              mem_cs,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dataIn,
  input  logic [DATA_W-1:0] mem_dataOut
);

  // Wide enough to hold LOCK_MAX itself so the terminal compare is exact.
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             last, last_nxt;        // port granted most recently (tie-break pointer)
  logic [CNT_W-1:0] lock_cnt, lock_cnt_nxt;
  logic [CNT_W-1:0] lock_cnt_inc;
  logic             lerr0_nxt, lerr1_nxt;

  // Two-entry read owner pipeline: stage 1 = command on the memory bus,
  // stage 2 = data on mem_dataOut (represented directly by rvalid0/rvalid1).
  logic             rd1_vld;
  logic             rd1_own;

  // Selected access (valid only when any_gnt).
  logic              any_gnt;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    case (state)
      ST_LOCK0: gnt0 = req0;
      ST_LOCK1: gnt1 = req1;
      default: begin
        if (req0 && req1) begin
          // last==1 means port 1 went last, so port 0 takes the tie.
          if ((FIXED_PRIO != 0) || last) gnt0 = 1'b1;
          else                           gnt1 = 1'b1;
        end else begin
          gnt0 = req0;
          gnt1 = req1;
        end
      end
    endcase
  end

  assign any_gnt   = gnt0 | gnt1;
  assign sel_we    = gnt1 ? we1    : we0;
  assign sel_lock  = gnt1 ? lock1  : lock0;
  assign sel_addr  = gnt1 ? addr1  : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;

  // ---------------------------------------------------------------------------
  // Lock state machine
  // ---------------------------------------------------------------------------
  assign lock_cnt_inc = lock_cnt + 1'b1;

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    last_nxt     = any_gnt ? gnt1 : last;
    lerr0_nxt    = 1'b0;
    lerr1_nxt    = 1'b0;
    case (state)
      ST_ARB: begin
        if (any_gnt && sel_lock) begin
          state_nxt    = gnt1 ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_nxt = '0;
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        // Only the owner can hold a grant here, so any_gnt implies owner access.
        if (any_gnt) begin
          lock_cnt_nxt = '0;
          if (!sel_lock) state_nxt = ST_ARB;
        end else if (lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
          // Owner went quiet too long: drop the lock and hand the next tie
          // to the other port by pretending the owner was granted last.
          state_nxt    = ST_ARB;
          lock_cnt_nxt = '0;
          last_nxt     = (state == ST_LOCK1);
          lerr0_nxt    = (state == ST_LOCK0);
          lerr1_nxt    = (state == ST_LOCK1);
        end else begin
          lock_cnt_nxt = lock_cnt_inc;
        end
      end
      default: begin
        state_nxt    = ST_ARB;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, memory command issue and read return
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ARB;
      last       <= 1'b1;
      lock_cnt   <= '0;
      lock_err0  <= 1'b0;
      lock_err1  <= 1'b0;
      mem_cs     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_dataIn <= '0;
      rd1_vld    <= 1'b0;
      rd1_own    <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      lock_cnt  <= lock_cnt_nxt;
      lock_err0 <= lerr0_nxt;
      lock_err1 <= lerr1_nxt;

      mem_cs <= any_gnt;
      // Gating we with the grant keeps mem_we low whenever mem_cs is low.
      mem_we <= any_gnt & sel_we;
      if (any_gnt) begin
        mem_addr   <= sel_addr;
        mem_dataIn <= sel_wdata;
      end

      rd1_vld <= any_gnt & ~sel_we;
      rd1_own <= gnt1;
      rvalid0 <= rd1_vld & ~rd1_own;
      rvalid1 <= rd1_vld &  rd1_own;
    end
  end

  // Read data is the raw memory output; rvalid tells the owner when to take it.
  assign rdata0 = mem_dataOut;
  assign rdata1 = mem_dataOut;

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps

module tb_dmem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int LMAX = 16;

  logic clk;
  logic rst_n;
  logic req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic gnt0, gnt1, rvalid0, rvalid1, lock_err0, lock_err1;
  logic [DW-1:0] rdata0, rdata1;
  logic mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dataIn, mem_dataOut;

  // fixed-priority instance driven by the same requests
  logic fp_gnt0, fp_gnt1, fp_rvalid0, fp_rvalid1, fp_lerr0, fp_lerr1;
  logic [DW-1:0] fp_rdata0, fp_rdata1, fp_mem_din;
  logic fp_mem_cs, fp_mem_we;
  logic [AW-1:0] fp_mem_addr;
  logic [DW-1:0] fp_mem_dout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // behavioural single-port memory with a backdoor write port for preloading
  logic [DW-1:0] tmem [0:(1<<AW)-1];
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_dat;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .LOCK_MAX(LMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .lock_err0(lock_err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .lock_err1(lock_err1),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1), .LOCK_MAX(LMAX)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .gnt0(fp_gnt0), .rvalid0(fp_rvalid0), .rdata0(fp_rdata0), .lock_err0(fp_lerr0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .gnt1(fp_gnt1), .rvalid1(fp_rvalid1), .rdata1(fp_rdata1), .lock_err1(fp_lerr1),
    .mem_cs(fp_mem_cs), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_dataIn(fp_mem_din),
    .mem_dataOut(fp_mem_dout)
  );

  assign fp_mem_dout = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bd_we) tmem[bd_addr] <= bd_dat;
    else if (mem_cs) begin
      if (mem_we) tmem[mem_addr] <= mem_dataIn;
      else        mem_dataOut    <= tmem[mem_addr];
    end
  end

  task automatic clear_inputs;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    #1;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL rst_mem_cs: got %0b want 0", mem_cs); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %0b want 0", mem_we); end
    checks++; if (mem_addr !== '0 || mem_dataIn !== '0) begin errors++; $display("FAIL rst_mem_bus: addr %0h din %0h want 0", mem_addr, mem_dataIn); end
    checks++; if ({rvalid0, rvalid1, lock_err0, lock_err1} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {rvalid0, rvalid1, lock_err0, lock_err1}); end
    @(negedge clk);
    rst_n = 1;
    req0 = 1; req1 = 1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL rst_first_tie: got gnt0/1=%b want 10", {gnt0, gnt1}); end
    idle(4);
  endtask

  task automatic test_write_read;
    do_reset();
    req0 = 1; we0 = 1; addr0 = 10'd4; wdata0 = 32'd999;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wr_gnt0: got %0b want 1", gnt0); end
    @(negedge clk);
    we0 = 0;
    #1;
    checks++; if ({mem_cs, mem_we} !== 2'b11 || mem_addr !== 10'd4 || mem_dataIn !== 32'd999) begin
      errors++; $display("FAIL wr_issue: cs/we=%b addr=%0d din=%0d want 11/4/999", {mem_cs, mem_we}, mem_addr, mem_dataIn); end
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rd_gnt0: got %0b want 1", gnt0); end
    @(negedge clk);
    req0 = 0;
    #1;
    checks++; if ({mem_cs, mem_we} !== 2'b10 || rvalid0 !== 1'b0) begin
      errors++; $display("FAIL rd_issue: cs/we=%b rvalid0=%0b want 10/0", {mem_cs, mem_we}, rvalid0); end
    @(negedge clk); #1;
    checks++; if (rvalid0 !== 1'b1 || rdata0 !== 32'd999 || rvalid1 !== 1'b0) begin
      errors++; $display("FAIL rd_return: rvalid0=%0b rdata0=%0d rvalid1=%0b want 1/999/0", rvalid0, rdata0, rvalid1); end
    @(negedge clk); #1;
    checks++; if (rvalid0 !== 1'b0 || mem_cs !== 1'b0) begin errors++; $display("FAIL rd_single_pulse: rvalid0=%0b cs=%0b want 0/0", rvalid0, mem_cs); end
    idle(3);
  endtask

  task automatic test_round_robin;
    logic [1:0] want;
    do_reset();
    req0 = 1; req1 = 1; addr0 = 10'd1; addr1 = 10'd2;
    for (int i = 0; i < 4; i++) begin
      #1;
      want = (i % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if ({gnt0, gnt1} !== want) begin errors++; $display("FAIL rr_cycle%0d: gnt0/1=%b want %b", i, {gnt0, gnt1}, want); end
      checks++; if ({fp_gnt0, fp_gnt1} !== 2'b10) begin errors++; $display("FAIL fixed_prio_cycle%0d: gnt0/1=%b want 10", i, {fp_gnt0, fp_gnt1}); end
      @(negedge clk);
    end
    idle(4);
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bd_we = 1; bd_addr = AW'(i); bd_dat = 32'(100 + i);
    end
    @(negedge clk);
    bd_we = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin req1 = 1; we1 = 0; addr1 = AW'(i); end
      else req1 = 0;
      #1;
      if (i < 4) begin
        checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL b2b_gnt1_%0d: got %0b want 1", i, gnt1); end
      end
      if (i >= 2) begin
        checks++; if (rvalid1 !== 1'b1 || rdata1 !== 32'(100 + i - 2)) begin
          errors++; $display("FAIL b2b_rdata_%0d: rvalid1=%0b rdata1=%0d want 1/%0d", i - 2, rvalid1, rdata1, 100 + i - 2); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (rvalid1 !== 1'b0) begin errors++; $display("FAIL b2b_tail: rvalid1=%0b want 0", rvalid1); end
    idle(3);
  endtask

  task automatic test_lock_release;
    do_reset();
    req0 = 1; we0 = 0; addr0 = 10'd5; lock0 = 1;
    req1 = 1; we1 = 0; addr1 = 10'd7;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL lock_take: gnt0/1=%b want 10", {gnt0, gnt1}); end
    @(negedge clk);
    req0 = 0; lock0 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL lock_hold_%0d: gnt1=%0b want 0", i, gnt1); end
      @(negedge clk);
    end
    req0 = 1; we0 = 1; addr0 = 10'd5; wdata0 = 32'h55; lock0 = 0;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL unlock_access: gnt0/1=%b want 10", {gnt0, gnt1}); end
    @(negedge clk);
    req0 = 0;
    #1;
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL after_unlock: gnt1=%0b want 1", gnt1); end
    idle(4);
  endtask

  task automatic test_lock_timeout;
    do_reset();
    req0 = 1; we0 = 0; addr0 = 10'd9; lock0 = 1;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL to_take: gnt0=%0b want 1", gnt0); end
    @(negedge clk);
    req0 = 0; lock0 = 0; req1 = 1; addr1 = 10'd3;
    // locked for LMAX cycles, released with the error pulse on the next one
    for (int i = 1; i <= LMAX + 1; i++) begin
      #1;
      if (i <= LMAX) begin
        checks++; if (gnt1 !== 1'b0 || lock_err0 !== 1'b0) begin
          errors++; $display("FAIL to_locked_%0d: gnt1=%0b lock_err0=%0b want 0/0", i, gnt1, lock_err0); end
      end else begin
        checks++; if (lock_err0 !== 1'b1 || lock_err1 !== 1'b0 || gnt1 !== 1'b1) begin
          errors++; $display("FAIL to_release: lock_err0=%0b lock_err1=%0b gnt1=%0b want 1/0/1", lock_err0, lock_err1, gnt1); end
      end
      @(negedge clk);
    end
    #1;
    checks++; if (lock_err0 !== 1'b0) begin errors++; $display("FAIL to_pulse_width: lock_err0=%0b want 0", lock_err0); end
    idle(4);
  endtask

  task automatic test_reset_midop;
    do_reset();
    req0 = 1; we0 = 0; addr0 = 10'd4;
    #1;
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL mid_gnt0: got %0b want 1", gnt0); end
    @(negedge clk);
    req0 = 0;
    rst_n = 0;
    #1;
    checks++; if (mem_cs !== 1'b0) begin errors++; $display("FAIL mid_cs_clear: mem_cs=%0b want 0", mem_cs); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL mid_no_rvalid_%0d: rvalid0=%0b want 0", i, rvalid0); end
      @(negedge clk);
    end
    req0 = 1; req1 = 1;
    #1;
    checks++; if ({gnt0, gnt1} !== 2'b10) begin errors++; $display("FAIL mid_first_tie: gnt0/1=%b want 10", {gnt0, gnt1}); end
    idle(4);
  endtask

  typedef struct {
    int          due;
    int          port;
    logic [DW-1:0] dat;
  } rd_exp_t;

  task automatic test_random;
    logic [DW-1:0] ref_mem [0:15];
    rd_exp_t rq[$];
    rd_exp_t e;
    bit p_req[2], p_we[2], p_lock[2];
    logic [AW-1:0] p_addr[2];
    logic [DW-1:0] p_wdat[2];
    int owner, idle_cnt, last, g;
    bit x_cs, x_we, x_lerr[2], ev0, ev1;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_din;
    localparam int N = 500;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bd_we = 1; bd_addr = AW'(i); bd_dat = $urandom; ref_mem[i] = bd_dat;
    end
    @(negedge clk);
    bd_we = 0;
    do_reset();
    owner = -1; idle_cnt = 0; last = 1;
    x_cs = 0; x_we = 0; x_addr = '0; x_din = '0; x_lerr[0] = 0; x_lerr[1] = 0;
    for (int k = 0; k < 2; k++) begin p_req[k] = 0; p_we[k] = 0; p_lock[k] = 0; p_addr[k] = '0; p_wdat[k] = '0; end

    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (i >= N - 6) p_req[k] = 0;
        else if (!p_req[k] && $urandom_range(0, 99) < 60) begin
          p_req[k] = 1; p_we[k] = $urandom_range(0, 1) == 1;
          p_addr[k] = AW'($urandom_range(0, 15)); p_wdat[k] = $urandom;
          p_lock[k] = $urandom_range(0, 99) < 12;
        end else if (p_req[k] && $urandom_range(0, 99) < 4) p_req[k] = 0;
      end
      req0 = p_req[0]; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wdat[0]; lock0 = p_lock[0];
      req1 = p_req[1]; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wdat[1]; lock1 = p_lock[1];
      #1;
      // expected grant from the arbitration rules
      if (owner >= 0) g = p_req[owner] ? owner : -1;
      else if (p_req[0] && p_req[1]) g = (last == 0) ? 1 : 0;
      else if (p_req[0]) g = 0;
      else if (p_req[1]) g = 1;
      else g = -1;

      checks++; if (gnt0 !== (g == 0) || gnt1 !== (g == 1)) begin
        errors++; $display("FAIL rnd_gnt c%0d: gnt0/1=%b%b want %b%b", i, gnt0, gnt1, g == 0, g == 1); end
      checks++; if (mem_cs !== x_cs || (x_cs && (mem_we !== x_we || mem_addr !== x_addr || mem_dataIn !== x_din)) || (!x_cs && mem_we !== 1'b0)) begin
        errors++; $display("FAIL rnd_issue c%0d: cs=%0b we=%0b addr=%0h din=%0h want %0b/%0b/%0h/%0h", i, mem_cs, mem_we, mem_addr, mem_dataIn, x_cs, x_we, x_addr, x_din); end
      checks++; if (lock_err0 !== x_lerr[0] || lock_err1 !== x_lerr[1]) begin
        errors++; $display("FAIL rnd_lock_err c%0d: got %b%b want %b%b", i, lock_err0, lock_err1, x_lerr[0], x_lerr[1]); end
      ev0 = rq.size() > 0 && rq[0].due == cyc && rq[0].port == 0;
      ev1 = rq.size() > 0 && rq[0].due == cyc && rq[0].port == 1;
      checks++; if (rvalid0 !== ev0 || rvalid1 !== ev1) begin
        errors++; $display("FAIL rnd_rvalid c%0d: got %b%b want %b%b", i, rvalid0, rvalid1, ev0, ev1); end
      if (ev0 || ev1) begin
        e = rq.pop_front();
        checks++; if ((ev0 ? rdata0 : rdata1) !== e.dat) begin
          errors++; $display("FAIL rnd_rdata c%0d port%0d: got %0h want %0h", i, e.port, ev0 ? rdata0 : rdata1, e.dat); end
      end

      // advance the reference model to the next cycle
      x_lerr[0] = 0; x_lerr[1] = 0;
      x_cs = (g >= 0);
      if (g >= 0) begin
        x_we = p_we[g]; x_addr = p_addr[g]; x_din = p_wdat[g]; last = g;
        if (p_we[g]) ref_mem[p_addr[g][3:0]] = p_wdat[g];
        else begin e.due = cyc + 2; e.port = g; e.dat = ref_mem[p_addr[g][3:0]]; rq.push_back(e); end
      end
      if (owner < 0) begin
        if (g >= 0 && p_lock[g]) begin owner = g; idle_cnt = 0; end
      end else if (g == owner) begin
        if (p_lock[g]) idle_cnt = 0;
        else owner = -1;
      end else begin
        idle_cnt++;
        if (idle_cnt == LMAX) begin x_lerr[owner] = 1; last = owner; owner = -1; idle_cnt = 0; end
      end
      if (g >= 0) p_req[g] = 0;
      @(negedge clk);
    end
    checks++; if (rq.size() != 0) begin errors++; $display("FAIL rnd_drain: %0d reads never returned, want 0", rq.size()); end
    idle(2);
  endtask

  initial begin
    rst_n = 1;
    bd_we = 0; bd_addr = '0; bd_dat = '0;
    clear_inputs();
    test_reset();
    test_write_read();
    test_round_robin();
    test_back_to_back();
    test_lock_release();
    test_lock_timeout();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
